// File: rtl/reg_load_arbiter_pkg.sv
// Shared definitions for reg_load_arbiter: FSM state encoding and counter width.
// Encoding 2'd3 is unused and is steered back to S_IDLE by the FSM.
package reg_load_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam int unsigned WRCNT_W = 16;

endpackage

// File: rtl/reg_load_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching ptr+1, ptr+2, ... mod NREQ.
// Produces a one-hot winner plus a valid flag.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = ({{(32-PW){1'b0}}, ptr} + k) % NREQ;
            if (!valid && req[idx[PW-1:0]]) begin
                winner[idx[PW-1:0]] = 1'b1;
                valid               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one W-bit register among NREQ requesters (IDLE -> LOAD -> ACK).
// Optional 16-bit committed-load counter on port wrcnt when REG_ARB_WRCNT_EN is defined.
module reg_load_arbiter
    import reg_load_arbiter_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned NREQ = 4
) (
    input  logic                ck,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   din,
    output logic [NREQ-1:0]     gnt,
    output logic                ld,
    output logic [NREQ-1:0]     ack,
    output logic [W-1:0]        q,
    output logic                busy
`ifdef REG_ARB_WRCNT_EN
    ,
    output logic [WRCNT_W-1:0]  wrcnt
`endif
);

    localparam int unsigned PW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] pick;
    logic            pick_valid;
    logic [PW-1:0]   g_idx;
    logic [W-1:0]    d_sel;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick),
        .valid  (pick_valid)
    );

    // gnt is one-hot, so an OR-mux over requesters selects the granted data.
    always_comb begin
        g_idx = '0;
        d_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                g_idx = PW'(i);
                d_sel = d_sel | din[i*W +: W];
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:  state_nxt = pick_valid ? S_LOAD : S_IDLE;
            S_LOAD:  state_nxt = S_ACK;
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            gnt <= '0;
            q   <= '0;
            ptr <= PW'(NREQ - 1);
        end else begin
            case (state)
                S_IDLE:  if (pick_valid) gnt <= pick;
                S_LOAD:  q <= d_sel;
                S_ACK: begin
                    ptr <= g_idx;
                    gnt <= '0;
                end
                default: gnt <= '0;
            endcase
        end
    end

    assign ld   = (state == S_LOAD);
    assign busy = (state != S_IDLE);
    assign ack  = (state == S_ACK) ? gnt : '0;

`ifdef REG_ARB_WRCNT_EN
    always_ff @(posedge ck) begin
        if (rst)                 wrcnt <= '0;
        else if (state == S_ACK) wrcnt <= wrcnt + WRCNT_W'(1);
    end
`endif

endmodule
